approx_product_accumulator: RTL and testbench

APPROX_PRODUCT_ACCUMULATOR -- requirements
Module: approx_product_accumulator

---
 rtl/approx_product_accumulator.sv | 125 ++++++++++++
 tb/tb_approx_product_accumulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_product_accumulator.sv
// Groups 8-bit approximate-multiplier products into sums of up to TERMS items with valid/ready on both sides.
// Define APPROX_ACC_SATURATE_EN to clamp the sum on overflow instead of wrapping it.
module approx_product_accumulator #(
    parameter int TERMS = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [7:0]       prod_data,
    input  logic             prod_last,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [ACC_W-1:0] sum_data,
    output logic [7:0]       sum_count,
    output logic             ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0]       TERMS_C = 8'(TERMS);
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    logic [1:0]       r_rst_sync;
    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf;
    logic             r_sum_valid;
    logic             r_prod_ready;

    logic             w_prod_hs;
    logic [7:0]       w_cnt_inc;
    logic [ACC_W:0]   w_add;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] w_prod_ext;

    assign w_prod_hs  = prod_valid & r_prod_ready;
    assign w_cnt_inc  = r_cnt + 8'd1;
    assign w_prod_ext = {{(ACC_W-8){1'b0}}, prod_data};
    // One extra bit on the left captures the carry-out of the accumulator MSB.
    assign w_add      = {1'b0, r_acc} + {1'b0, w_prod_ext};

`ifdef APPROX_ACC_SATURATE_EN
    assign w_acc_next = (w_add[ACC_W] || r_ovf) ? ACC_MAX : w_add[ACC_W-1:0];
`else
    assign w_acc_next = w_add[ACC_W-1:0];
`endif

    // Reset release synchronizer; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Group accumulation FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_acc        <= {ACC_W{1'b0}};
            r_cnt        <= 8'd0;
            r_ovf        <= 1'b0;
            r_sum_valid  <= 1'b0;
            r_prod_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Ready only opens once the released reset has crossed the synchronizer.
                    r_prod_ready <= r_rst_sync[1];
                    if (w_prod_hs) begin
                        r_acc <= w_prod_ext;
                        r_cnt <= 8'd1;
                        r_ovf <= 1'b0;
                        if (prod_last || (TERMS_C == 8'd1)) begin
                            r_state      <= ST_HOLD;
                            r_sum_valid  <= 1'b1;
                            r_prod_ready <= 1'b0;
                        end else begin
                            r_state <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (w_prod_hs) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_inc;
                        r_ovf <= r_ovf | w_add[ACC_W];
                        if (prod_last || (w_cnt_inc == TERMS_C)) begin
                            r_state      <= ST_HOLD;
                            r_sum_valid  <= 1'b1;
                            r_prod_ready <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (sum_ready) begin
                        r_state      <= ST_IDLE;
                        r_sum_valid  <= 1'b0;
                        r_prod_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_sum_valid  <= 1'b0;
                    r_prod_ready <= 1'b0;
                end
            endcase
        end
    end

    assign prod_ready = r_prod_ready;
    assign sum_valid  = r_sum_valid;
    assign sum_data   = r_acc;
    assign sum_count  = r_cnt;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_approx_product_accumulator.sv
// Scoreboard bench: the stimulus side predicts each group sum from plain integer arithmetic; a monitor checks it.
module tb_approx_product_accumulator;

    localparam int TERMS = 4;
    localparam int ACC_W = 9;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             prod_valid;
    logic             prod_ready;
    logic [7:0]       prod_data;
    logic             prod_last;
    logic             sum_valid;
    logic             sum_ready;
    logic [ACC_W-1:0] sum_data;
    logic [7:0]       sum_count;
    logic             ovf;

    approx_product_accumulator #(.TERMS(TERMS), .ACC_W(ACC_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data), .prod_last(prod_last),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data), .sum_count(sum_count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int count;
        bit ovf;
        int due;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   grp_sum = 0;
    int   grp_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_mode = 1;
    bit   prev_sv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // sum_ready: 0 = held low, 1 = held high, 2 = random back-pressure
    always @(negedge clk) begin
        if (rdy_mode == 2) sum_ready = ($urandom_range(0, 2) != 0);
        else               sum_ready = (rdy_mode == 1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a group is the list of accepted products; sum is ordinary integer addition.
    function automatic void model_accept(input int d, input bit last);
        exp_t e;
        grp_sum += d;
        grp_cnt++;
        if (last || grp_cnt == TERMS) begin
`ifdef APPROX_ACC_SATURATE_EN
            e.data = (grp_sum > MAXV) ? MAXV : grp_sum;
`else
            e.data = grp_sum % (MAXV + 1);
`endif
            e.count = grp_cnt;
            e.ovf   = (grp_sum > MAXV);
            e.due   = cyc + 1;
            exp_q.push_back(e);
            grp_sum = 0;
            grp_cnt = 0;
        end
    endfunction

    task automatic send(input int d, input bit last);
        int t = 0;
        prod_valid = 1'b1;
        prod_data  = 8'(d);
        prod_last  = last;
        while (!prod_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!prod_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: product %0d not accepted after %0d cycles", d, t);
        end else begin
            model_accept(d, last);
        end
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || sum_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending sums, required 0", exp_q.size());
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sum_valid"},  64'(sum_valid),  64'd0);
        chk({tag, "_prod_ready"}, 64'(prod_ready), 64'd0);
        chk({tag, "_sum_data"},   64'(sum_data),   64'd0);
        chk({tag, "_sum_count"},  64'(sum_count),  64'd0);
        chk({tag, "_ovf"},        64'(ovf),        64'd0);
    endtask

    // Monitor: pops an expectation on each new sum, then checks it stays stable while held.
    always @(negedge clk) begin
        if (sum_valid) begin
            if (!prev_sv) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_sum: got sum %0d count %0d, required no sum", sum_data, sum_count);
                end else begin
                    cur = exp_q.pop_front();
                    chk("sum_data",    64'(sum_data),  64'(cur.data));
                    chk("sum_count",   64'(sum_count), 64'(cur.count));
                    chk("sum_ovf",     64'(ovf),       64'(cur.ovf));
                    chk("sum_latency", 64'(cyc),       64'(cur.due));
                end
            end else begin
                chk("sum_data_stable",  64'(sum_data),  64'(cur.data));
                chk("sum_count_stable", 64'(sum_count), 64'(cur.count));
            end
            chk("prod_ready_in_hold", 64'(prod_ready), 64'd0);
        end
        prev_sv = sum_valid;
    end

    initial begin
        int t;
        rst_n      = 1'b0;
        prod_valid = 1'b0;
        prod_data  = 8'd0;
        prod_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", 64'(prod_ready), 64'd0);
        @(negedge clk);

        // Full group back-to-back, then an early close.
        send(10, 1'b0); send(20, 1'b0); send(30, 1'b0); send(40, 1'b0);
        drain();
        send(7, 1'b0); send(9, 1'b1);
        drain();

        // Back-pressure: sum held while an upstream product waits.
        rdy_mode = 0;
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
        t = 0;
        while (!sum_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("hold_reached", 64'(sum_valid), 64'd1);
        prod_valid = 1'b1;
        prod_data  = 8'd99;
        prod_last  = 1'b1;
        repeat (5) @(negedge clk);
        rdy_mode = 1;
        send(99, 1'b1);
        drain();

        // Overflow within a group.
        send(255, 1'b0); send(255, 1'b0); send(255, 1'b0); send(255, 1'b0);
        drain();

        // Reset in the middle of a group discards it.
        send(50, 1'b0); send(60, 1'b0);
        chk("running_sum",   64'(sum_data),  64'd110);
        chk("running_count", 64'(sum_count), 64'd2);
        chk("running_valid", 64'(sum_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        grp_sum = 0;
        grp_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(5, 1'b0); send(5, 1'b0); send(5, 1'b0); send(5, 1'b0);
        drain();

        // Random products with gaps, random early close and random back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(int'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0));
        end
        if (grp_cnt != 0) send(int'($urandom_range(0, 255)), 1'b1);
        rdy_mode = 1;
        drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
